// File: rtl/memory_stage_pkg.sv
// Shared widths, state encoding and small helpers for the pipeline memory stage.
// The EX/MEM latch, data cache and register file all agree on these widths.
package memory_stage_pkg;

  localparam int WORD_WIDTH           = 32;
  localparam int REGISTER_INDEX_WIDTH = 5;
  localparam int BYTE_WIDTH           = 8;
  localparam int BYTES_PER_WORD       = WORD_WIDTH / BYTE_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WAIT  = 2'd1,
    WRITEBACK = 2'd2
  } state_t;

  // Word accesses must sit on a 4-byte boundary; byte accesses are always legal.
  function automatic logic is_misaligned(input logic byte_access,
                                         input logic [1:0] addr_low);
    return !byte_access && (addr_low != 2'd0);
  endfunction

  // Register 0 is hardwired to zero, so it is never a write target.
  function automatic logic writes_register(
      input logic                            reg_write,
      input logic [REGISTER_INDEX_WIDTH-1:0] index);
    return reg_write && (index != '0);
  endfunction

endpackage

// File: rtl/memory_stage_load_aligner.sv
// Byte-lane select and sign extension for loads returned by the data cache.
// Word loads pass the cache word through unchanged.
module load_aligner
  import memory_stage_pkg::*;
(
  input  logic [1:0]            addr_low,
  input  logic                  byte_access,
  input  logic [WORD_WIDTH-1:0] rdata,
  output logic [WORD_WIDTH-1:0] data
);

  logic [BYTE_WIDTH-1:0] lanes [BYTES_PER_WORD];
  logic [BYTE_WIDTH-1:0] selected;

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign lanes[gi] = rdata[BYTE_WIDTH*gi +: BYTE_WIDTH];
    end
  endgenerate

  always_comb begin
    selected = lanes[addr_low];
    if (byte_access) begin
      data = {{(WORD_WIDTH-BYTE_WIDTH){selected[BYTE_WIDTH-1]}}, selected};
    end else begin
      data = rdata;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: ALU results go straight to writeback, loads/stores run a
// request/ready handshake with the data cache while stalling upstream.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic                            cu_mem_to_reg_in,
  input  logic                            cu_mem_write_in,
  input  logic                            cu_reg_write_in,
  input  logic                            cu_byte_in,
  input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
  input  logic [WORD_WIDTH-1:0]           alu_result_in,
  input  logic [WORD_WIDTH-1:0]           store_data_in,
  output logic                            stall_out,
  output logic                            cache_req_out,
  output logic                            cache_we_out,
  output logic                            cache_byte_out,
  output logic [WORD_WIDTH-1:0]           cache_addr_out,
  output logic [WORD_WIDTH-1:0]           cache_wdata_out,
  input  logic                            cache_ready_in,
  input  logic [WORD_WIDTH-1:0]           cache_rdata_in,
  output logic                            wb_enable_out,
  output logic [REGISTER_INDEX_WIDTH-1:0] wb_index_out,
  output logic [WORD_WIDTH-1:0]           wb_data_out,
  output logic                            misaligned_out
);

  state_t                            state_reg;
  logic                              stall_reg;
  logic                              cache_req_reg;
  logic                              cache_we_reg;
  logic                              cache_byte_reg;
  logic [WORD_WIDTH-1:0]             cache_addr_reg;
  logic [WORD_WIDTH-1:0]             cache_wdata_reg;
  logic                              wb_enable_reg;
  logic [REGISTER_INDEX_WIDTH-1:0]   wb_index_reg;
  logic [WORD_WIDTH-1:0]             wb_data_reg;
  logic                              misaligned_reg;

  // Pending memory operation, held while the cache handshake is in flight.
  logic                              pending_load_reg;
  logic                              pending_reg_write_reg;
  logic [REGISTER_INDEX_WIDTH-1:0]   pending_index_reg;

  logic                              is_mem_op;
  logic [WORD_WIDTH-1:0]             load_data;

  assign is_mem_op = cu_mem_to_reg_in || cu_mem_write_in;

  // Alignment uses the held request address, which is stable through MEM_WAIT.
  load_aligner u_load_aligner (
    .addr_low    (cache_addr_reg[1:0]),
    .byte_access (cache_byte_reg),
    .rdata       (cache_rdata_in),
    .data        (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg             <= IDLE;
      stall_reg             <= 1'b0;
      cache_req_reg         <= 1'b0;
      cache_we_reg          <= 1'b0;
      cache_byte_reg        <= 1'b0;
      cache_addr_reg        <= '0;
      cache_wdata_reg       <= '0;
      wb_enable_reg         <= 1'b0;
      wb_index_reg          <= '0;
      wb_data_reg           <= '0;
      misaligned_reg        <= 1'b0;
      pending_load_reg      <= 1'b0;
      pending_reg_write_reg <= 1'b0;
      pending_index_reg     <= '0;
    end else begin
      // Single-cycle pulses unless reloaded below.
      wb_enable_reg  <= 1'b0;
      misaligned_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (valid_in) begin
            if (!is_mem_op) begin
              wb_enable_reg <= writes_register(cu_reg_write_in, destination_register_in);
              wb_index_reg  <= destination_register_in;
              wb_data_reg   <= alu_result_in;
            end else if (is_misaligned(cu_byte_in, alu_result_in[1:0])) begin
              misaligned_reg <= 1'b1;
            end else begin
              cache_req_reg         <= 1'b1;
              cache_we_reg          <= cu_mem_write_in;
              cache_byte_reg        <= cu_byte_in;
              cache_addr_reg        <= alu_result_in;
              cache_wdata_reg       <= store_data_in;
              pending_load_reg      <= cu_mem_to_reg_in;
              pending_reg_write_reg <= writes_register(cu_reg_write_in,
                                                       destination_register_in);
              pending_index_reg     <= destination_register_in;
              state_reg             <= MEM_WAIT;
              stall_reg             <= 1'b1;
            end
          end
        end

        MEM_WAIT: begin
          if (cache_ready_in) begin
            cache_req_reg <= 1'b0;
            if (pending_load_reg) begin
              wb_enable_reg <= pending_reg_write_reg;
              wb_index_reg  <= pending_index_reg;
              wb_data_reg   <= load_data;
              state_reg     <= WRITEBACK;
            end else begin
              state_reg <= IDLE;
              stall_reg <= 1'b0;
            end
          end
        end

        WRITEBACK: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end

        default: begin
          state_reg     <= IDLE;
          stall_reg     <= 1'b0;
          cache_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign stall_out       = stall_reg;
  assign cache_req_out   = cache_req_reg;
  assign cache_we_out    = cache_we_reg;
  assign cache_byte_out  = cache_byte_reg;
  assign cache_addr_out  = cache_addr_reg;
  assign cache_wdata_out = cache_wdata_reg;
  assign wb_enable_out   = wb_enable_reg;
  assign wb_index_out    = wb_index_reg;
  assign wb_data_out     = wb_data_reg;
  assign misaligned_out  = misaligned_reg;

endmodule
